// File: rtl/key_pkg.sv
// Shared definitions for the key input chain (debounce filter, release
// detector, click decoder): gesture state encoding and default counts
// for a 50 MHz system clock.
package key_pkg;

    // Default counter width and counts at 50 MHz
    localparam int CNT_W_DEF      = 26;
    localparam int RELEASE_CNT_DEF = 1_000_000;   // 20 ms
    localparam int GAP_CNT_DEF     = 12_500_000;  // 250 ms
    localparam int LONG_CNT_DEF    = 50_000_000;  // 1 s
    localparam int REPEAT_CNT_DEF  = 10_000_000;  // 200 ms

    // Gesture classifier states
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS1    = 3'd1,
        GAP       = 3'd2,
        PRESS2    = 3'd3,
        LONG_HOLD = 3'd4
    } key_state_t;

endpackage

// File: rtl/key_release_det.sv
// Release detector: brings the raw key level into the sys_clk domain and
// flags the single cycle in which the key has been seen released for
// RELEASE_CNT consecutive cycles.
module key_release_det
    import key_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int RELEASE_CNT = RELEASE_CNT_DEF
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_in,
    output logic rel_pulse
);

    localparam logic [CNT_W-1:0] REL_MAX  = CNT_W'(RELEASE_CNT);
    localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(RELEASE_CNT - 1);

    logic             key_meta;
    logic             key_s;
    logic [CNT_W-1:0] rel_cnt;

    // Two-flop synchronizer; reset value is the released level
    always_ff @(posedge sys_clk) begin
        // NOTE: non-blocking here so key_s takes the old key_meta, forming a real two-stage chain.
        if (!sys_rst_n) begin
            key_meta <= 1'b1;
            key_s    <= 1'b1;
        end else begin
            key_meta <= key_in;
            key_s    <= key_meta;
        end
    end

    // Count consecutive released cycles, saturating so the pulse fires only once
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n || !key_s) begin
            rel_cnt <= '0;
        end else if (rel_cnt != REL_MAX) begin
            rel_cnt <= rel_cnt + CNT_W'(1);
        end
    end

    assign rel_pulse = key_s && (rel_cnt == REL_LAST);

endmodule

// File: rtl/key_click_decoder.sv
// Key gesture decoder: turns debounced press pulses and the raw key level
// into one-cycle single_click / double_click / long_press pulses.
// Optional auto-repeat while a long press is held: define KEY_REPEAT_EN.
module key_click_decoder
    import key_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int RELEASE_CNT = RELEASE_CNT_DEF,
    parameter int GAP_CNT     = GAP_CNT_DEF,
    parameter int LONG_CNT    = LONG_CNT_DEF,
    parameter int REPEAT_CNT  = REPEAT_CNT_DEF
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_flag,
    input  logic key_in,
    output logic single_click,
    output logic double_click,
    output logic long_press,
    output logic long_repeat,
    output logic busy
);

    localparam longint CNT_LIMIT = longint'(1) << CNT_W;

    // Every count must fit the counters and be at least one cycle
    if (RELEASE_CNT < 1 || GAP_CNT < 1 || LONG_CNT < 1 || REPEAT_CNT < 1 ||
        longint'(RELEASE_CNT) >= CNT_LIMIT || longint'(GAP_CNT) >= CNT_LIMIT ||
        longint'(LONG_CNT) >= CNT_LIMIT || longint'(REPEAT_CNT) >= CNT_LIMIT) begin : g_cfg_check
        $error("key_click_decoder: count parameter out of range for CNT_W");
    end

    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CNT - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);

    key_state_t       state;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] gap_cnt;
    logic             rel_pulse;

`ifdef KEY_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CNT - 1);
    logic [CNT_W-1:0] rep_cnt;
`else
    assign long_repeat = 1'b0;
`endif

    key_release_det #(
        .CNT_W       (CNT_W),
        .RELEASE_CNT (RELEASE_CNT)
    ) u_release_det (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .key_in    (key_in),
        .rel_pulse (rel_pulse)
    );

    // Gesture classifier with registered one-cycle pulse outputs
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state        <= IDLE;
            hold_cnt     <= '0;
            gap_cnt      <= '0;
            single_click <= 1'b0;
            double_click <= 1'b0;
            long_press   <= 1'b0;
`ifdef KEY_REPEAT_EN
            rep_cnt      <= '0;
            long_repeat  <= 1'b0;
`endif
        end else begin
            single_click <= 1'b0;
            double_click <= 1'b0;
            long_press   <= 1'b0;
`ifdef KEY_REPEAT_EN
            long_repeat  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (key_flag) begin
                        state    <= PRESS1;
                        hold_cnt <= '0;
                    end
                end
                PRESS1: begin
                    // Long-press timeout outranks a release seen in the same cycle
                    if (hold_cnt == LONG_LAST) begin
                        long_press <= 1'b1;
                        state      <= LONG_HOLD;
`ifdef KEY_REPEAT_EN
                        rep_cnt    <= '0;
`endif
                    end else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                        if (rel_pulse) begin
                            state   <= GAP;
                            gap_cnt <= '0;
                        end
                    end
                end
                GAP: begin
                    // A second press wins over the gap timeout in the same cycle
                    if (key_flag) begin
                        state <= PRESS2;
                    end else if (gap_cnt == GAP_LAST) begin
                        single_click <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + CNT_W'(1);
                    end
                end
                PRESS2: begin
                    if (rel_pulse) begin
                        double_click <= 1'b1;
                        state        <= IDLE;
                    end
                end
                LONG_HOLD: begin
                    if (rel_pulse) begin
                        state <= IDLE;
`ifdef KEY_REPEAT_EN
                    end else if (rep_cnt == REP_LAST) begin
                        rep_cnt     <= '0;
                        long_repeat <= 1'b1;
                    end else begin
                        rep_cnt <= rep_cnt + CNT_W'(1);
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_key_click_decoder.sv
// Self-checking bench for key_click_decoder with small counts
// (RELEASE_CNT=4, GAP_CNT=20, LONG_CNT=50, REPEAT_CNT=10).
// Cycle n is the interval after rising edge n of a scenario; inputs are
// driven on the falling edge inside that cycle and captured at edge n+1.
module tb_key_click_decoder;

    localparam int CNT_W       = 26;
    localparam int RELEASE_CNT = 4;
    localparam int GAP_CNT     = 20;
    localparam int LONG_CNT    = 50;
    localparam int REPEAT_CNT  = 10;

`ifdef KEY_REPEAT_EN
    localparam bit REPEAT_ON = 1'b1;
`else
    localparam bit REPEAT_ON = 1'b0;
`endif

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    logic key_flag  = 1'b0;
    logic key_in    = 1'b1;
    logic single_click, double_click, long_press, long_repeat, busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int base     = 0;
    bit chk_en   = 1'b0;

    key_click_decoder #(
        .CNT_W       (CNT_W),
        .RELEASE_CNT (RELEASE_CNT),
        .GAP_CNT     (GAP_CNT),
        .LONG_CNT    (LONG_CNT),
        .REPEAT_CNT  (REPEAT_CNT)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .key_flag     (key_flag),
        .key_in       (key_in),
        .single_click (single_click),
        .double_click (double_click),
        .long_press   (long_press),
        .long_repeat  (long_repeat),
        .busy         (busy)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc - base);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Gesture progress is tracked with absolute due-times (edge numbers)
    // rather than counters; the release detector is a run length of
    // released samples.
    typedef enum int {G_NONE, G_FIRST_DOWN, G_WAIT_SECOND, G_SECOND_DOWN, G_LONG_HELD} g_phase_t;

    g_phase_t phase = G_NONE;
    int  long_due, single_due, rep_due;
    int  run      = 0;
    bit  lvl_d1   = 1'b1;   // key level one edge back in the sync chain
    bit  lvl_s    = 1'b1;   // key level as the decoder sees it
    bit  m_rel    = 1'b0;
    bit  rel_prev;
    bit  exp_single = 0, exp_double = 0, exp_long = 0, exp_rep = 0, exp_busy = 0;

    always @(posedge sys_clk) begin
        cyc      = cyc + 1;
        rel_prev = m_rel;
        exp_single = 0; exp_double = 0; exp_long = 0; exp_rep = 0;
        if (!sys_rst_n) begin
            phase  = G_NONE;
            lvl_d1 = 1'b1;
            lvl_s  = 1'b1;
            run    = 1;
        end else begin
            lvl_s  = lvl_d1;
            lvl_d1 = key_in;
            run    = lvl_s ? run + 1 : 0;
            case (phase)
                G_NONE:
                    if (key_flag) begin
                        phase    = G_FIRST_DOWN;
                        long_due = cyc + LONG_CNT;
                    end
                G_FIRST_DOWN:
                    if (cyc == long_due) begin
                        exp_long = 1;
                        phase    = G_LONG_HELD;
                        rep_due  = cyc + REPEAT_CNT;
                    end else if (rel_prev) begin
                        phase      = G_WAIT_SECOND;
                        single_due = cyc + GAP_CNT;
                    end
                G_WAIT_SECOND:
                    if (key_flag) begin
                        phase = G_SECOND_DOWN;
                    end else if (cyc == single_due) begin
                        exp_single = 1;
                        phase      = G_NONE;
                    end
                G_SECOND_DOWN:
                    if (rel_prev) begin
                        exp_double = 1;
                        phase      = G_NONE;
                    end
                G_LONG_HELD:
                    if (rel_prev) begin
                        phase = G_NONE;
                    end else if (cyc == rep_due) begin
                        exp_rep = REPEAT_ON;
                        rep_due = rep_due + REPEAT_CNT;
                    end
                default: phase = G_NONE;
            endcase
        end
        m_rel    = (run == RELEASE_CNT);
        exp_busy = (phase != G_NONE);
    end

    // Every-cycle comparison against the model, away from the rising edge
    always @(negedge sys_clk) begin
        if (chk_en) begin
            check("single_click", int'(single_click), int'(exp_single));
            check("double_click", int'(double_click), int'(exp_double));
            check("long_press",   int'(long_press),   int'(exp_long));
            check("long_repeat",  int'(long_repeat),  int'(exp_rep));
            check("busy",         int'(busy),         int'(exp_busy));
        end
    end

    // Pulse bookkeeping for the hand-computed expectations
    int n_single, n_double, n_long, n_rep;
    int t_single, t_double, t_long, t_rep_first;

    always @(negedge sys_clk) begin
        if (single_click === 1'b1) begin n_single++; t_single = cyc - base; end
        if (double_click === 1'b1) begin n_double++; t_double = cyc - base; end
        if (long_press   === 1'b1) begin n_long++;   t_long   = cyc - base; end
        if (long_repeat  === 1'b1) begin
            if (n_rep == 0) t_rep_first = cyc - base;
            n_rep++;
        end
    end

    task automatic begin_scenario();
        @(negedge sys_clk);
        base = cyc;
        n_single = 0; n_double = 0; n_long = 0; n_rep = 0;
        t_single = -1; t_double = -1; t_long = -1; t_rep_first = -1;
    endtask

    // Wait for the falling edge inside scenario cycle rel
    task automatic at(input int rel);
        while (cyc - base < rel) @(negedge sys_clk);
    endtask

    task automatic press_flag(input int rel);
        at(rel);     key_flag = 1'b1;
        at(rel + 1); key_flag = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge sys_clk);
        chk_en = 1'b1;
        check("rst_single", int'(single_click), 0);
        check("rst_double", int'(double_click), 0);
        check("rst_long",   int'(long_press),   0);
        check("rst_repeat", int'(long_repeat),  0);
        check("rst_busy",   int'(busy),         0);
        sys_rst_n = 1'b1;
        repeat (10) @(negedge sys_clk);

        // Single click: release seen at 19, click 20 cycles later
        begin_scenario();
        at(5);  key_in = 1'b0;
        press_flag(10);
        at(14); key_in = 1'b1;
        at(39); check("s1_busy_39", int'(busy), 1);
        at(40); check("s1_busy_40", int'(busy), 0);
        at(70);
        check("s1_n_single", n_single, 1);
        check("s1_t_single", t_single, 40);
        check("s1_n_double", n_double, 0);
        check("s1_n_long",   n_long,   0);

        // Double click with an ignored extra press pulse during the second press
        begin_scenario();
        at(5);  key_in = 1'b0;
        press_flag(10);
        at(14); key_in = 1'b1;
        at(24); key_in = 1'b0;
        press_flag(28);
        press_flag(30);
        at(32); key_in = 1'b1;
        at(80);
        check("s2_n_double", n_double, 1);
        check("s2_t_double", t_double, 38);
        check("s2_n_single", n_single, 0);
        check("s2_n_long",   n_long,   0);

        // Long press held until 199, auto-repeat every 10 cycles if enabled
        begin_scenario();
        at(5);  key_in = 1'b0;
        press_flag(10);
        at(199); key_in = 1'b1;
        at(204); check("s3_busy_204", int'(busy), 1);
        at(205); check("s3_busy_205", int'(busy), 0);
        at(240);
        check("s3_n_long",     n_long,      1);
        check("s3_t_long",     t_long,      61);
        check("s3_n_single",   n_single,    0);
        check("s3_n_double",   n_double,    0);
        check("s3_n_repeat",   n_rep,       REPEAT_ON ? 14 : 0);
        check("s3_t_repeat",   t_rep_first, REPEAT_ON ? 71 : -1);

        // Second press arrives in the last gap cycle: double, never single
        begin_scenario();
        at(5);  key_in = 1'b0;
        press_flag(10);
        at(14); key_in = 1'b1;
        at(30); key_in = 1'b0;
        press_flag(39);
        at(45); key_in = 1'b1;
        at(90);
        check("s4_n_single", n_single, 0);
        check("s4_n_double", n_double, 1);
        check("s4_t_double", t_double, 51);

        // Three-cycle release glitch is not a release
        begin_scenario();
        at(5);  key_in = 1'b0;
        press_flag(10);
        at(20); key_in = 1'b1;
        at(23); key_in = 1'b0;
        at(30); key_in = 1'b1;
        at(80);
        check("s5_n_single", n_single, 1);
        check("s5_t_single", t_single, 56);
        check("s5_n_double", n_double, 0);

        // One-cycle reset during the gap abandons the gesture
        begin_scenario();
        at(5);  key_in = 1'b0;
        press_flag(10);
        at(14); key_in = 1'b1;
        at(25); sys_rst_n = 1'b0;
        at(26); sys_rst_n = 1'b1;
        check("s6_busy_rst",   int'(busy),         0);
        check("s6_single_rst", int'(single_click), 0);
        at(80);
        check("s6_n_single", n_single, 0);
        check("s6_n_double", n_double, 0);
        check("s6_n_long",   n_long,   0);
        check("s6_busy_end", int'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Run-time bound
    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
